rd_logic: RTL and testbench

RD_LOGIC -- requirements
Module: rd_logic

---
 rtl/rd_logic_pkg.sv | 25 ++
 rtl/b_to_g.sv | 13 +
 rtl/g_to_b.sv | 16 +
 rtl/rd_logic.sv | 91 +++++++++
 tb/tb_rd_logic.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/rd_logic_pkg.sv
// Shared FIFO package: default address width and Gray/binary conversion helpers
// used by both the read-side and write-side pointer logic.
package rd_logic_pkg;

  // Default memory address width; FIFO depth is 2**FifoAddrSize.
  localparam int unsigned FifoAddrSize = 4;

  // Widest pointer the helpers handle; callers truncate to their own width.
  localparam int unsigned PtrMaxW = 32;

  function automatic logic [PtrMaxW-1:0] bin_to_gray(input logic [PtrMaxW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits do not disturb the result.
  function automatic logic [PtrMaxW-1:0] gray_to_bin(input logic [PtrMaxW-1:0] gray);
    logic [PtrMaxW-1:0] bin;
    bin[PtrMaxW-1] = gray[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/b_to_g.sv
// Binary-to-Gray converter, N bits, purely combinational.
//   bin_i  : binary input
//   gray_o : Gray-coded output
module b_to_g #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/g_to_b.sv
// Gray-to-binary converter, N bits, purely combinational.
//   gray_i : Gray-coded input
//   bin_o  : binary output
// Each binary bit is the XOR of all Gray bits from the MSB down to itself.
module g_to_b #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/rd_logic.sv
// Read-side pointer and flag logic of an asynchronous FIFO.
//   rd_clk_i       : read-domain clock
//   rd_rst_i       : asynchronous active-high reset
//   rd_en_i        : read request, accepted only while not empty
//   rq2_wptr_i     : Gray write pointer, already synchronized into rd_clk
//   rd_ptr_o       : binary read address to the memory (combinational from rbin)
//   rd_ptr_gray_o  : registered Gray read pointer for the write domain
//   empty_o        : registered empty flag
//   almost_empty_o : registered, fill level <= AE_THRESH
//   rd_count_o     : registered fill level 0..2**ADDR_SIZE
//   rd_valid_o     : one cycle after each accepted read
//   underflow_o    : sticky, set by a read attempted while empty
module rd_logic
  import rd_logic_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = FifoAddrSize,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                 rd_clk_i,
  input  logic                 rd_rst_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_SIZE:0]   rq2_wptr_i,
  output logic [ADDR_SIZE-1:0] rd_ptr_o,
  output logic [ADDR_SIZE:0]   rd_ptr_gray_o,
  output logic                 empty_o,
  output logic                 almost_empty_o,
  output logic [ADDR_SIZE:0]   rd_count_o,
  output logic                 rd_valid_o,
  output logic                 underflow_o
);

  localparam logic [ADDR_SIZE:0] AeThresh = AE_THRESH[ADDR_SIZE:0];

  logic [ADDR_SIZE:0] rbin_q, rbin_d;
  logic [ADDR_SIZE:0] rgray_q, rgray_d;
  logic [ADDR_SIZE:0] count_q, count_d;
  logic [ADDR_SIZE:0] wbin_s;
  logic               empty_q, aempty_q, valid_q, underflow_q;
  logic               rd_accept;

  b_to_g #(
    .N (ADDR_SIZE + 1)
  ) u_b_to_g (
    .bin_i  (rbin_d),
    .gray_o (rgray_d)
  );

  g_to_b #(
    .N (ADDR_SIZE + 1)
  ) u_g_to_b (
    .gray_i (rq2_wptr_i),
    .bin_o  (wbin_s)
  );

  always_comb begin
    rd_accept = rd_en_i & ~empty_q;
    rbin_d    = rbin_q + {{ADDR_SIZE{1'b0}}, rd_accept};
    // Modulo 2**(ADDR_SIZE+1) difference; the extra pointer bit makes full read as DEPTH.
    count_d   = wbin_s - rbin_d;
  end

  always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
    if (rd_rst_i) begin
      rbin_q      <= '0;
      rgray_q     <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rgray_q     <= rgray_d;
      count_q     <= count_d;
      // Uses the post-read pointer so the edge consuming the last entry raises empty.
      empty_q     <= (rgray_d == rq2_wptr_i);
      aempty_q    <= (count_d <= AeThresh);
      valid_q     <= rd_accept;
      underflow_q <= underflow_q | (rd_en_i & empty_q);
    end
  end

  assign rd_ptr_o       = rbin_q[ADDR_SIZE-1:0];
  assign rd_ptr_gray_o  = rgray_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = aempty_q;
  assign rd_count_o     = count_q;
  assign rd_valid_o     = valid_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_rd_logic.sv
// Self-checking bench for rd_logic (ADDR_SIZE=4, AE_THRESH=2).
module tb_rd_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic [4:0] rq2_wptr;
  logic [3:0] rd_ptr;
  logic [4:0] rd_ptr_gray;
  logic       empty, almost_empty, rd_valid, underflow;
  logic [4:0] rd_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [3:0] ptr;
    logic [4:0] gray;
    logic       empty;
    logic [4:0] cnt;
    logic       ae;
    logic       valid;
    logic       uf;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: binary write/read counts and flags.
  logic [4:0] m_w, m_r;
  logic       m_empty, m_uf;

  always #5 clk = ~clk;

  rd_logic #(
    .ADDR_SIZE (4),
    .AE_THRESH (2)
  ) dut (
    .rd_clk_i       (clk),
    .rd_rst_i       (rst),
    .rd_en_i        (rd_en),
    .rq2_wptr_i     (rq2_wptr),
    .rd_ptr_o       (rd_ptr),
    .rd_ptr_gray_o  (rd_ptr_gray),
    .empty_o        (empty),
    .almost_empty_o (almost_empty),
    .rd_count_o     (rd_count),
    .rd_valid_o     (rd_valid),
    .underflow_o    (underflow)
  );

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".rd_ptr"}, 32'(rd_ptr), 32'd0);
    check({tag, ".gray"}, 32'(rd_ptr_gray), 32'd0);
    check({tag, ".count"}, 32'(rd_count), 32'd0);
    check({tag, ".empty"}, 32'(empty), 32'd1);
    check({tag, ".ae"}, 32'(almost_empty), 32'd1);
    check({tag, ".valid"}, 32'(rd_valid), 32'd0);
    check({tag, ".uf"}, 32'(underflow), 32'd0);
  endtask

  // Drive one cycle, push the model's prediction, then pop and compare after the edge.
  task automatic step(input logic en, input logic [4:0] w);
    exp_t e;
    logic acc;
    logic [4:0] r_n, cnt;
    @(negedge clk);
    rd_en    = en;
    rq2_wptr = gray5(w);
    acc      = en && !m_empty;
    r_n      = m_r + {4'd0, acc};
    cnt      = w - r_n;
    m_uf     = m_uf | (en & m_empty);
    m_empty  = (w == r_n);
    m_r      = r_n;
    m_w      = w;
    e.ptr    = r_n[3:0];
    e.gray   = gray5(r_n);
    e.empty  = m_empty;
    e.cnt    = cnt;
    e.ae     = (cnt <= 5'd2);
    e.valid  = acc;
    e.uf     = m_uf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
      check("rd_ptr", 32'(rd_ptr), 32'(e.ptr));
      check("rd_ptr_gray", 32'(rd_ptr_gray), 32'(e.gray));
      check("empty", 32'(empty), 32'(e.empty));
      check("rd_count", 32'(rd_count), 32'(e.cnt));
      check("almost_empty", 32'(almost_empty), 32'(e.ae));
      check("rd_valid", 32'(rd_valid), 32'(e.valid));
      check("underflow", 32'(underflow), 32'(e.uf));
    end
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rd_en    = 1'b0;
    rq2_wptr = '0;
    #1 rst   = 1'b1;
    #1;
    check_reset_vals(tag);
    @(posedge clk);
    #1;
    check_reset_vals({tag, ".held"});
    @(negedge clk);
    rst     = 1'b0;
    m_w     = '0;
    m_r     = '0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
  endtask

  initial begin
    logic [4:0] w;
    rst      = 1'b1;
    rd_en    = 1'b0;
    rq2_wptr = '0;
    m_w      = '0;
    m_r      = '0;
    m_empty  = 1'b1;
    m_uf     = 1'b0;
    #2;
    check_reset_vals("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Three entries arrive, then three back-to-back reads drain them.
    step(1'b0, 5'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 5'd3);
    // Read while empty sets sticky underflow.
    step(1'b1, 5'd3);
    for (int i = 0; i < 10; i++) step(1'b0, 5'd3);

    // Mid-stream reset with a pending read request and underflow set.
    @(negedge clk);
    rd_en = 1'b1;
    do_reset("midrst");

    // Full FIFO, then drain across the wrap point.
    step(1'b0, 5'd16);
    for (int i = 0; i < 16; i++) step(1'b1, 5'd16);
    step(1'b1, 5'd16);

    // Write advance coinciding with the read of the last entry.
    step(1'b0, 5'd18);
    step(1'b1, 5'd18);
    step(1'b1, 5'd19);
    step(1'b1, 5'd19);
    step(1'b0, 5'd19);

    // Random traffic, never more than 16 entries outstanding.
    w = m_w;
    for (int i = 0; i < 60; i++) begin
      if (((w - m_r) < 5'd16) && ($urandom_range(0, 2) != 0)) w = w + 5'd1;
      step(1'($urandom_range(0, 1)), w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
